// File: rtl/elevator_ctrl.sv
// Elevator cabin controller: latches floor requests, schedules them with a
// SCAN policy, and sequences the engine and door from plant sensor feedback.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_CLOSE | door close command active, waiting for sensor_door == 10
// S_IDLE  | door closed, engine stopped, choosing the next request
// S_MOVE  | engine running in dir, tracking floor pulses
// S_OPEN  | door open command active, waiting for sensor_door == 01
// S_HOLD  | door fully open, dwelling DOOR_HOLD cycles
// S_FAULT | sticky fault, engine and door idle until reset
module elevator_ctrl #(
    parameter int  FLOORS       = 8,
    parameter int  DOOR_HOLD    = 10,
    parameter int  DOOR_TIMEOUT = 20,
    parameter int  MOVE_TIMEOUT = 50,
    localparam int FW           = (FLOORS > 1) ? $clog2(FLOORS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLOORS-1:0] buttons,
    input  logic              sensor_up,
    input  logic              sensor_down,
    input  logic [1:0]        sensor_door,
    output logic [1:0]        engine,
    output logic [1:0]        door,
    output logic [FW-1:0]     floor,
    output logic [FLOORS-1:0] pending,
    output logic              fault
);

    localparam int T_MAX0 = (DOOR_TIMEOUT > MOVE_TIMEOUT) ? DOOR_TIMEOUT : MOVE_TIMEOUT;
    localparam int T_MAX  = (DOOR_HOLD > T_MAX0) ? DOOR_HOLD : T_MAX0;
    // Saturate one above the largest limit so "timer > limit" can still fire for it.
    localparam int TW = $clog2(T_MAX + 2);

    localparam logic [TW-1:0] T_SAT      = TW'(T_MAX + 1);
    localparam logic [TW-1:0] T_DOOR     = TW'(DOOR_TIMEOUT);
    localparam logic [TW-1:0] T_MOVE     = TW'(MOVE_TIMEOUT);
    localparam logic [TW-1:0] T_HOLD_END = TW'(DOOR_HOLD - 1);
    localparam logic [FW-1:0] TOP_FLOOR  = FW'(FLOORS - 1);

    localparam logic [1:0] ENG_STOP   = 2'b00;
    localparam logic [1:0] ENG_UP     = 2'b01;
    localparam logic [1:0] ENG_DOWN   = 2'b10;
    localparam logic [1:0] DOOR_IDLE  = 2'b00;
    localparam logic [1:0] DOOR_OPEN  = 2'b01;
    localparam logic [1:0] DOOR_CLOSE = 2'b10;
    localparam logic [1:0] SENS_OPEN  = 2'b01;
    localparam logic [1:0] SENS_SHUT  = 2'b10;

    typedef enum logic [2:0] {
        S_CLOSE,
        S_IDLE,
        S_MOVE,
        S_OPEN,
        S_HOLD,
        S_FAULT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              dir_up;
    logic              dir_up_nxt;
    logic [FW-1:0]     floor_nxt;
    logic [TW-1:0]     timer;
    logic              timer_clr;
    logic              step_taken;
    logic              hold_press;
    logic              req_here;
    logic              req_above;
    logic              req_below;
    logic [FLOORS-1:0] floor_oh;
    logic [FLOORS-1:0] btn_mask;
    logic [FLOORS-1:0] clr;

    // Summarise latched requests relative to the current floor.
    always_comb begin
        req_above = 1'b0;
        req_below = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (i > int'(floor)) req_above = req_above | pending[i];
            if (i < int'(floor)) req_below = req_below | pending[i];
        end
        floor_oh = FLOORS'(1) << floor;
        req_here = |(pending & floor_oh);
    end

    // Pressing the current floor while the door is open extends the dwell.
    always_comb begin
        hold_press = (state == S_HOLD) && (|(buttons & floor_oh));
    end

    // Next-state, direction and floor tracking.
    always_comb begin
        state_nxt  = state;
        dir_up_nxt = dir_up;
        floor_nxt  = floor;
        step_taken = 1'b0;
        case (state)
            S_CLOSE: begin
                if (sensor_door == SENS_SHUT) state_nxt = S_IDLE;
                else if (timer > T_DOOR)      state_nxt = S_FAULT;
            end
            S_IDLE: begin
                if (req_here) begin
                    state_nxt = S_OPEN;
                end else if (dir_up ? req_above : req_below) begin
                    state_nxt = S_MOVE;
                end else if (dir_up ? req_below : req_above) begin
                    dir_up_nxt = ~dir_up;
                    state_nxt  = S_MOVE;
                end
            end
            S_MOVE: begin
                if (sensor_up) begin
                    if (!dir_up || floor == TOP_FLOOR) begin
                        state_nxt = S_FAULT;
                    end else begin
                        floor_nxt  = floor + FW'(1);
                        step_taken = 1'b1;
                    end
                end else if (sensor_down) begin
                    if (dir_up || floor == '0) begin
                        state_nxt = S_FAULT;
                    end else begin
                        floor_nxt  = floor - FW'(1);
                        step_taken = 1'b1;
                    end
                end else if (timer > T_MOVE) begin
                    state_nxt = S_FAULT;
                end
                if (step_taken && pending[floor_nxt]) state_nxt = S_OPEN;
            end
            S_OPEN: begin
                if (sensor_door == SENS_OPEN) state_nxt = S_HOLD;
                else if (timer > T_DOOR)      state_nxt = S_FAULT;
            end
            S_HOLD: begin
                if (timer >= T_HOLD_END && !hold_press) state_nxt = S_CLOSE;
            end
            S_FAULT: begin
                state_nxt = S_FAULT;
            end
            default: begin
                state_nxt = S_FAULT;
            end
        endcase
        // Both floor sensors at once means the plant is inconsistent.
        if (sensor_up && sensor_down && state != S_FAULT) begin
            state_nxt  = S_FAULT;
            dir_up_nxt = dir_up;
            floor_nxt  = floor;
            step_taken = 1'b0;
        end
    end

    // Request masking on the open floor and clearing on door-open entry.
    always_comb begin
        btn_mask = (state == S_OPEN || state == S_HOLD) ? floor_oh : '0;
        clr      = (state_nxt == S_OPEN && state != S_OPEN) ? (FLOORS'(1) << floor_nxt) : '0;
        timer_clr = (state_nxt != state) || step_taken || hold_press;
    end

    // State, direction and floor registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_CLOSE;
            dir_up <= 1'b1;
            floor  <= '0;
        end else begin
            state  <= state_nxt;
            dir_up <= dir_up_nxt;
            floor  <= floor_nxt;
        end
    end

    // Shared saturating timer, restarted on every state change or floor pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (timer_clr) begin
            timer <= '0;
        end else if (timer != T_SAT) begin
            timer <= timer + TW'(1);
        end
    end

    // Request latch keeps accumulating in every state, including fault.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= (pending | (buttons & ~btn_mask)) & ~clr;
        end
    end

    // Registered plant commands decoded from the upcoming state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            engine <= ENG_STOP;
            door   <= DOOR_IDLE;
            fault  <= 1'b0;
        end else begin
            engine <= (state_nxt == S_MOVE) ? (dir_up_nxt ? ENG_UP : ENG_DOWN) : ENG_STOP;
            case (state_nxt)
                S_OPEN:  door <= DOOR_OPEN;
                S_CLOSE: door <= DOOR_CLOSE;
                default: door <= DOOR_IDLE;
            endcase
            fault  <= (state_nxt == S_FAULT);
        end
    end

endmodule

// File: tb/tb_elevator_ctrl.sv
// Testbench for elevator_ctrl: scenario tasks with a stop-order scoreboard.
module tb_elevator_ctrl;

    localparam int FLOORS       = 8;
    localparam int DOOR_HOLD    = 10;
    localparam int DOOR_TIMEOUT = 20;
    localparam int MOVE_TIMEOUT = 50;
    localparam int FW           = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [FLOORS-1:0] buttons = '0;
    logic              sensor_up = 1'b0;
    logic              sensor_down = 1'b0;
    logic [1:0]        sensor_door = 2'b10;
    logic [1:0]        engine;
    logic [1:0]        door;
    logic [FW-1:0]     floor;
    logic [FLOORS-1:0] pending;
    logic              fault;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    elevator_ctrl #(
        .FLOORS(FLOORS),
        .DOOR_HOLD(DOOR_HOLD),
        .DOOR_TIMEOUT(DOOR_TIMEOUT),
        .MOVE_TIMEOUT(MOVE_TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .buttons(buttons),
        .sensor_up(sensor_up),
        .sensor_down(sensor_down),
        .sensor_door(sensor_door),
        .engine(engine),
        .door(door),
        .floor(floor),
        .pending(pending),
        .fault(fault)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_up();
        sensor_up = 1'b1;
        @(negedge clk);
        sensor_up = 1'b0;
    endtask

    task automatic pulse_down();
        sensor_down = 1'b1;
        @(negedge clk);
        sensor_down = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        buttons = '0;
        sensor_up = 1'b0;
        sensor_down = 1'b0;
        sensor_door = 2'b10;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
    endtask

    task automatic wait_door(input logic [1:0] val, input int max, output int cycles, output bit ok);
        ok = 1'b0;
        cycles = 0;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (door == val) begin
                cycles = i;
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Acts as the shaft: answers each engine command with a floor pulse.
    task automatic run_to_stop(output logic [1:0] first_eng, output bit ok);
        first_eng = 2'b00;
        ok = 1'b0;
        for (int i = 0; i < 4 * FLOORS; i++) begin
            if (door == 2'b01) begin
                ok = 1'b1;
                break;
            end
            if (engine != 2'b00 && first_eng == 2'b00) first_eng = engine;
            if (engine == 2'b01)      pulse_up();
            else if (engine == 2'b10) pulse_down();
            else                      step();
        end
    endtask

    task automatic door_cycle(output int hold_cycles, output bit ok);
        sensor_door = 2'b01;
        @(negedge clk);
        sensor_door = 2'b10;
        wait_door(2'b10, DOOR_HOLD + 5, hold_cycles, ok);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        buttons = '0;
        sensor_door = 2'b10;
        repeat (3) @(negedge clk);
        checks++;
        if ({engine, door, floor, pending, fault} !== {2'b00, 2'b00, 3'd0, 8'h00, 1'b0})
            begin errors++; $display("FAIL reset_held got %b exp 0", {engine, door, floor, pending, fault}); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({engine, door, floor, pending, fault} !== {2'b00, 2'b00, 3'd0, 8'h00, 1'b0})
            begin errors++; $display("FAIL reset_idle got %b exp 0", {engine, door, floor, pending, fault}); end
    endtask

    task automatic test_serve_up();
        int cyc;
        int exp_f;
        bit ok;
        logic [6:0] exp_v;
        exp_q.push_back(3);
        buttons = 8'h08;
        @(negedge clk);
        buttons = '0;
        checks++;
        if ({engine, pending} !== {2'b00, 8'h08})
            begin errors++; $display("FAIL serve_latch got %b exp %b", {engine, pending}, {2'b00, 8'h08}); end
        @(negedge clk);
        checks++;
        if (engine !== 2'b01) begin errors++; $display("FAIL serve_start got %b exp 01", engine); end
        for (int p = 1; p <= 3; p++) begin
            pulse_up();
            exp_v = (p < 3) ? {FW'(p), 2'b01, 2'b00} : {3'd3, 2'b00, 2'b01};
            checks++;
            if ({floor, engine, door} !== exp_v)
                begin errors++; $display("FAIL serve_pulse%0d got %b exp %b", p, {floor, engine, door}, exp_v); end
        end
        exp_f = exp_q.pop_front();
        checks++;
        if (floor !== FW'(exp_f)) begin errors++; $display("FAIL serve_stop got %0d exp %0d", floor, exp_f); end
        checks++;
        if (pending !== 8'h00) begin errors++; $display("FAIL serve_clear got %h exp 00", pending); end
        door_cycle(cyc, ok);
        checks++;
        if (!ok || cyc != DOOR_HOLD)
            begin errors++; $display("FAIL serve_hold got %0d ok=%0d exp %0d", cyc, ok, DOOR_HOLD); end
    endtask

    task automatic test_hold_reload();
        int cyc;
        int exp_f;
        bit ok;
        exp_q.push_back(3);
        buttons = 8'h08;
        @(negedge clk);
        buttons = '0;
        checks++;
        if (door !== 2'b00) begin errors++; $display("FAIL latency_early got %b exp 00", door); end
        @(negedge clk);
        checks++;
        if (door !== 2'b01) begin errors++; $display("FAIL latency_open got %b exp 01", door); end
        exp_f = exp_q.pop_front();
        checks++;
        if ({floor, pending} !== {FW'(exp_f), 8'h00})
            begin errors++; $display("FAIL latency_stop got %b exp %b", {floor, pending}, {FW'(exp_f), 8'h00}); end
        sensor_door = 2'b01;
        @(negedge clk);
        sensor_door = 2'b10;
        repeat (5) @(negedge clk);
        buttons = 8'h08;
        @(negedge clk);
        buttons = '0;
        checks++;
        if (pending !== 8'h00) begin errors++; $display("FAIL hold_masked got %h exp 00", pending); end
        wait_door(2'b10, DOOR_HOLD + 5, cyc, ok);
        checks++;
        if (!ok || cyc != DOOR_HOLD)
            begin errors++; $display("FAIL hold_reload got %0d ok=%0d exp %0d", cyc, ok, DOOR_HOLD); end
        @(negedge clk);
    endtask

    task automatic test_scan();
        logic [1:0] eng;
        int cyc;
        int exp_f;
        bit ok;
        exp_q.push_back(6);
        exp_q.push_back(1);
        buttons = 8'h42;
        @(negedge clk);
        buttons = '0;
        run_to_stop(eng, ok);
        checks++;
        if (!ok || eng !== 2'b01) begin errors++; $display("FAIL scan_dir1 got %b ok=%0d exp 01", eng, ok); end
        exp_f = exp_q.pop_front();
        checks++;
        if ({floor, pending} !== {FW'(exp_f), 8'h02})
            begin errors++; $display("FAIL scan_stop1 got %b exp %b", {floor, pending}, {FW'(exp_f), 8'h02}); end
        door_cycle(cyc, ok);
        run_to_stop(eng, ok);
        checks++;
        if (!ok || eng !== 2'b10) begin errors++; $display("FAIL scan_dir2 got %b ok=%0d exp 10", eng, ok); end
        exp_f = exp_q.pop_front();
        checks++;
        if ({floor, pending} !== {FW'(exp_f), 8'h00})
            begin errors++; $display("FAIL scan_stop2 got %b exp %b", {floor, pending}, {FW'(exp_f), 8'h00}); end
        door_cycle(cyc, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL scan_close got timeout exp door 10"); end
    endtask

    task automatic test_fault_reverse();
        do_reset();
        buttons = 8'h20;
        @(negedge clk);
        buttons = '0;
        @(negedge clk);
        checks++;
        if (engine !== 2'b01) begin errors++; $display("FAIL rev_start got %b exp 01", engine); end
        pulse_down();
        checks++;
        if ({fault, engine, door, floor} !== {1'b1, 2'b00, 2'b00, 3'd0})
            begin errors++; $display("FAIL rev_fault got %b exp %b", {fault, engine, door, floor}, {1'b1, 7'd0}); end
        buttons = 8'h04;
        sensor_up = 1'b1;
        @(negedge clk);
        buttons = '0;
        sensor_up = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({fault, engine, door, floor, pending} !== {1'b1, 2'b00, 2'b00, 3'd0, 8'h24})
            begin errors++; $display("FAIL rev_sticky got %b exp %b", {fault, engine, door, floor, pending}, {1'b1, 7'd0, 8'h24}); end
    endtask

    task automatic test_fault_both();
        do_reset();
        buttons = 8'h04;
        @(negedge clk);
        buttons = '0;
        @(negedge clk);
        pulse_up();
        sensor_up = 1'b1;
        sensor_down = 1'b1;
        @(negedge clk);
        sensor_up = 1'b0;
        sensor_down = 1'b0;
        checks++;
        if ({fault, engine, floor} !== {1'b1, 2'b00, 3'd1})
            begin errors++; $display("FAIL both_fault got %b exp %b", {fault, engine, floor}, {1'b1, 2'b00, 3'd1}); end
    endtask

    task automatic test_move_timeout();
        int cyc;
        do_reset();
        buttons = 8'h10;
        @(negedge clk);
        buttons = '0;
        @(negedge clk);
        cyc = 0;
        for (int i = 1; i <= MOVE_TIMEOUT + 10; i++) begin
            @(negedge clk);
            if (fault) begin
                cyc = i;
                break;
            end
        end
        checks++;
        if (cyc <= MOVE_TIMEOUT || cyc > MOVE_TIMEOUT + 2 || engine !== 2'b00)
            begin errors++; $display("FAIL move_timeout got %0d eng=%b exp %0d..%0d eng=00", cyc, engine, MOVE_TIMEOUT + 1, MOVE_TIMEOUT + 2); end
        repeat (5) @(negedge clk);
        checks++;
        if (fault !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b exp 1", fault); end
    endtask

    task automatic test_reset_mid_move();
        do_reset();
        buttons = 8'h20;
        @(negedge clk);
        buttons = '0;
        @(negedge clk);
        pulse_up();
        checks++;
        if ({floor, engine, fault} !== {3'd1, 2'b01, 1'b0})
            begin errors++; $display("FAIL mid_pre got %b exp %b", {floor, engine, fault}, {3'd1, 2'b01, 1'b0}); end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({engine, door, floor, pending, fault} !== {2'b00, 2'b00, 3'd0, 8'h00, 1'b0})
            begin errors++; $display("FAIL mid_async got %b exp 0", {engine, door, floor, pending, fault}); end
        sensor_door = 2'b00;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({door, engine} !== {2'b10, 2'b00})
            begin errors++; $display("FAIL mid_close got %b exp 1000", {door, engine}); end
        sensor_door = 2'b10;
        @(negedge clk);
        checks++;
        if ({door, engine, floor} !== {2'b00, 2'b00, 3'd0})
            begin errors++; $display("FAIL mid_idle got %b exp 0", {door, engine, floor}); end
    endtask

    initial begin
        test_reset();
        test_serve_up();
        test_hold_reload();
        test_scan();
        test_fault_reverse();
        test_fault_both();
        test_move_timeout();
        test_reset_mid_move();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

endmodule
